// File: rtl/adc_spi_regbank_if.sv
// Host register bus for adc_spi_regbank: byte-enabled writes and strobed reads with a
// registered read-data return.
interface adc_spi_regbank_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              wr_en;
    logic [3:0]        be;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wdata;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rdata;
    logic              rd_rdy;

    modport master (
        output wr_en, be, wr_addr, wdata, rd_en, rd_addr,
        input  rdata, rd_rdy
    );

    modport slave (
        input  wr_en, be, wr_addr, wdata, rd_en, rd_addr,
        output rdata, rd_rdy
    );
endinterface

// File: rtl/adc_spi_regbank.sv
// ADC/SPI control register bank: CTRL fields, N-channel ADC capture, W1C status, maskable irq
// and an SPI command FIFO. Optional coherent ADC snapshot via ADC_SPI_REGBANK_SNAPSHOT_EN.
module adc_spi_regbank #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned ADC_W      = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstb,
    adc_spi_regbank_if.slave     bus,
    input  logic [NCH*ADC_W-1:0] adc_result,
    input  logic [NCH-1:0]       adc_valid,
    output logic [4:0]           adc_clk_dly,
    output logic                 is_10_bit,
    output logic [3:0]           out_cnt,
    output logic                 spi_d_rise_align,
    output logic [4:0]           spi_rw_len,
    output logic                 spi_cmd_valid,
    input  logic                 spi_cmd_ready,
    output logic                 spi_cmd_rd,
    output logic [31:0]          spi_cmd_data,
    input  logic                 spi_rsp_valid,
    input  logic [31:0]          spi_rsp_data,
    output logic                 irq
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = PW + 1;

    localparam logic [31:0] CtrlMask = 32'h1F01_F11F;
    localparam logic [31:0] StatMask = 32'h0003_0000 | ((32'h1 << NCH) - 32'h1);

    localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] AddrSpiTx  = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] AddrSpiCmd = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] AddrMask   = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] AddrRdata  = ADDR_W'(8'h20);

    logic [31:0]      ctrl_q, ctrl_d;
    logic [31:0]      status_q, status_d;
    logic [31:0]      mask_q, mask_d;
    logic [31:0]      spi_rdata_q, spi_rdata_d;
    logic [ADC_W-1:0] adc_res_q [NCH];
    logic [ADC_W-1:0] adc_res_d [NCH];
`ifdef ADC_SPI_REGBANK_SNAPSHOT_EN
    logic [ADC_W-1:0] shadow_q [NCH];
    logic [ADC_W-1:0] shadow_d [NCH];
`endif
    logic [32:0]      mem_q [FIFO_DEPTH];
    logic [32:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rd_rdy_q, rd_rdy_d;
    logic             irq_q, irq_d;

    logic [31:0] be_mask;
    logic        wr_ctrl, wr_tx, wr_cmd, wr_status, wr_mask;
    logic        fifo_full, fifo_empty;
    logic        push_req, push, pop, ovf_evt;
    logic [32:0] push_data;
    logic [31:0] stat_set, stat_clr;
    logic [31:0] rd_word;
    logic        adc_hit;
    logic [3:0]  adc_idx;

    assign be_mask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};

    assign wr_ctrl   = bus.wr_en && (bus.wr_addr == AddrCtrl);
    assign wr_tx     = bus.wr_en && (bus.wr_addr == AddrSpiTx);
    assign wr_cmd    = bus.wr_en && (bus.wr_addr == AddrSpiCmd);
    assign wr_status = bus.wr_en && (bus.wr_addr == AddrStatus);
    assign wr_mask   = bus.wr_en && (bus.wr_addr == AddrMask);

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));

    // Control, mask, status and capture registers
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = (ctrl_q & ~be_mask) | (bus.wdata & be_mask & CtrlMask);
        end

        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = (mask_q & ~be_mask) | (bus.wdata & be_mask & StatMask);
        end

        for (int i = 0; i < NCH; i++) begin
            adc_res_d[i] = adc_res_q[i];
            if (adc_valid[i]) begin
                adc_res_d[i] = adc_result[i*ADC_W +: ADC_W];
                if (ctrl_q[8]) begin
                    adc_res_d[i][1:0] = 2'b00;
                end
            end
        end

        spi_rdata_d = spi_rsp_valid ? spi_rsp_data : spi_rdata_q;

        stat_set            = '0;
        stat_set[NCH-1:0]   = adc_valid;
        stat_set[16]        = spi_rsp_valid;
        stat_set[17]        = ovf_evt;
        stat_clr            = wr_status ? (bus.wdata & be_mask) : '0;
        // Set is applied after clear so a same-cycle event wins over W1C.
        status_d            = ((status_q & ~stat_clr) | stat_set) & StatMask;

        irq_d = |(status_q & mask_q);
    end

`ifdef ADC_SPI_REGBANK_SNAPSHOT_EN
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_ctrl && bus.be[3] && bus.wdata[31]) begin
                shadow_d[i] = adc_res_q[i];
            end
        end
    end
`endif

    // Command FIFO
    always_comb begin
        push_req  = (wr_tx && (bus.be == 4'hF)) || (wr_cmd && bus.be[0] && bus.wdata[1]);
        push_data = wr_tx ? {1'b0, bus.wdata} : {1'b1, 32'h0};
        pop       = !fifo_empty && spi_cmd_ready;
        push      = push_req && (!fifo_full || pop);
        ovf_evt   = push_req && fifo_full && !pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // Read mux, sampled into the registered return path
    always_comb begin
        adc_idx = bus.rd_addr[5:2];
        adc_hit = (bus.rd_addr[ADDR_W-1:6] == (ADDR_W-6)'(1)) && (bus.rd_addr[1:0] == 2'b00);
        rd_word = '0;
        if (bus.rd_addr == AddrCtrl) begin
            rd_word = ctrl_q;
        end else if (bus.rd_addr == AddrSpiCmd) begin
            rd_word = {30'b0, fifo_full, fifo_empty} | ((32'(level_q) << 8) & 32'h0000_1F00);
        end else if (bus.rd_addr == AddrStatus) begin
            rd_word = status_q;
        end else if (bus.rd_addr == AddrMask) begin
            rd_word = mask_q;
        end else if (bus.rd_addr == AddrRdata) begin
            rd_word = spi_rdata_q;
        end else if (adc_hit) begin
            for (int i = 0; i < NCH; i++) begin
                if (adc_idx == 4'(i)) begin
`ifdef ADC_SPI_REGBANK_SNAPSHOT_EN
                    rd_word = 32'(shadow_q[i]);
`else
                    rd_word = 32'(adc_res_q[i]);
`endif
                end
            end
        end

        rd_rdy_d = bus.rd_en;
        rdata_d  = bus.rd_en ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ctrl_q      <= '0;
            status_q    <= '0;
            mask_q      <= '0;
            spi_rdata_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rdata_q     <= '0;
            rd_rdy_q    <= 1'b0;
            irq_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                adc_res_q[i] <= '0;
`ifdef ADC_SPI_REGBANK_SNAPSHOT_EN
                shadow_q[i]  <= '0;
`endif
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ctrl_q      <= ctrl_d;
            status_q    <= status_d;
            mask_q      <= mask_d;
            spi_rdata_q <= spi_rdata_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rdata_q     <= rdata_d;
            rd_rdy_q    <= rd_rdy_d;
            irq_q       <= irq_d;
            adc_res_q   <= adc_res_d;
`ifdef ADC_SPI_REGBANK_SNAPSHOT_EN
            shadow_q    <= shadow_d;
`endif
            mem_q       <= mem_d;
        end
    end

    assign adc_clk_dly      = ctrl_q[4:0];
    assign is_10_bit        = ctrl_q[8];
    assign out_cnt          = ctrl_q[15:12];
    assign spi_d_rise_align = ctrl_q[16];
    assign spi_rw_len       = ctrl_q[28:24];

    assign spi_cmd_valid = !fifo_empty;
    assign spi_cmd_rd    = mem_q[rd_ptr_q][32];
    assign spi_cmd_data  = mem_q[rd_ptr_q][31:0];

    assign bus.rdata  = rdata_q;
    assign bus.rd_rdy = rd_rdy_q;
    assign irq        = irq_q;
endmodule

// File: doc/adc_spi_regbank.md
Name: adc_spi_regbank

Overview:
- Parametrised successor of the ADC/SPI control register file, on the same 32-bit host register bus (wr_en/be/wr_addr/wdata, rd_en/rd_addr/rdata/rd_rdy).
- Adds N-channel ADC result capture with sticky new-data flags and write-1-to-clear status.
- Adds a maskable interrupt and a command FIFO that queues SPI write/read transactions to the SPI engine with a valid/ready handshake, replacing single-shot strobes.

Parameters:
NCH, 4, number of ADC channels (1..16)
ADC_W, 12, ADC result width (8..16)
FIFO_DEPTH, 4, SPI command FIFO entries (power of 2, >=2)
ADDR_W, 16, register address width

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
wr_en  in  1  register write strobe
be  in  4  byte enables for wdata
wr_addr  in  ADDR_W  write byte address
wdata  in  32  write data
rd_en  in  1  register read strobe
rd_addr  in  ADDR_W  read byte address
rdata  out  32  read data
rd_rdy  out  1  read data valid pulse
adc_result  in  NCH*ADC_W  packed results, channel i at [i*ADC_W +: ADC_W]
adc_valid  in  NCH  per-channel result strobe
adc_clk_dly  out  5  CTRL[4:0]
is_10_bit  out  1  CTRL[8]
out_cnt  out  4  CTRL[15:12]
spi_d_rise_align  out  1  CTRL[16]
spi_rw_len  out  5  CTRL[28:24]
spi_cmd_valid  out  1  FIFO not empty
spi_cmd_ready  in  1  SPI engine accepts head entry
spi_cmd_rd  out  1  head entry is a read
spi_cmd_data  out  32  head entry write data
spi_rsp_valid  in  1  SPI read-data strobe
spi_rsp_data  in  32  SPI read data
irq  out  1  registered interrupt

Behaviour:
- Reset (rstb low, async): all registers, outputs, FIFO pointers and level cleared to 0. Reset mid-transaction empties the FIFO; spi_cmd_valid drops immediately.
- Writes (wr_en high), byte-enabled per field byte:
  - 0x00 CTRL rw; same field positions as the output ports.
  - 0x04 SPI_TX wo; accepted only with be==4'hF, pushes {rd=0, wdata}. Any other be is ignored.
  - 0x08 SPI_CMD wo; be[0]&wdata[1] pushes {rd=1, 32'h0}.
  - 0x0C STATUS W1C, 0x10 IRQ_MASK rw.
  - Writes to read-only or unmapped addresses are ignored.
- Reads:
  - rd_en sampled at edge N; rdata and rd_rdy (1-cycle pulse) valid at edge N+1. Back-to-back reads give back-to-back rd_rdy.
  - rdata returns to 0 the cycle after rd_rdy falls. Unmapped addresses read 0; unused bits read 0.
- Read map:
  - 0x00 CTRL; 0x04 reads 0.
  - 0x08 FIFO_STAT: [0] empty, [1] full, [12:8] level.
  - 0x0C STATUS: [NCH-1:0] adc_new, [16] rsp_done, [17] overflow.
  - 0x10 IRQ_MASK, same bit layout as STATUS.
  - 0x20 SPI_RDATA.
  - 0x40+4*i ADC_RESULT[i], zero-extended, for i<NCH.
- ADC capture:
  - adc_valid[i] high: ADC_RESULT[i] <= slice, adc_new[i] <= 1.
  - With is_10_bit=1, captured value has bits [1:0] forced to 0.
- SPI response: spi_rsp_valid high loads SPI_RDATA and sets rsp_done.
- STATUS rules: a set event and a W1C clear of the same bit in the same cycle leaves the bit set (set wins). Writing 0 has no effect.
- FIFO:
  - Entries 33 bits. Head is presented combinationally on spi_cmd_rd/spi_cmd_data; pop on spi_cmd_valid&spi_cmd_ready.
  - Push while full without a same-cycle pop: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, level unchanged.
  - Push to an empty FIFO: spi_cmd_valid high the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; level is clog2(FIFO_DEPTH)+1 bits.
- irq <= |(STATUS & IRQ_MASK), registered: one cycle after the status or mask change.

Optional Feature:
- Macro ADC_SPI_REGBANK_SNAPSHOT_EN.
- Defined:
  - Writing CTRL with be[3] and wdata[31]=1 copies all live ADC results into shadow registers in one cycle; CTRL[31] reads 0.
  - ADC_RESULT reads return shadow values, so multi-channel reads are coherent.
  - adc_new is still driven by live captures.
- Undefined: CTRL[31] is ignored and reads return live results.

Test Plan:
- Reset, then read 0x00, 0x08, 0x0C -> rdata 0, 0x00000001 (empty), 0; rd_rdy exactly one cycle after each rd_en.
- Write 0x00=0x1F01_930A with be=4'hF -> spi_rw_len=0x1F, spi_d_rise_align=1, out_cnt=9, is_10_bit=1, adc_clk_dly=0x0A; readback 0x1F01_930A masked to mapped fields.
- spi_cmd_ready=0; push 5 words to 0x04 (DEPTH 4) -> FIFO_STAT full with level 4, STATUS[17]=1. Then ready=1 -> the 4 words pop in order, then spi_cmd_valid=0.
- adc_valid[2] with value 0xABC, is_10_bit=0 -> ADC_RESULT[2] (0x48)=0xABC, STATUS[2]=1. With IRQ_MASK=0x4, irq=1 one cycle later. W1C 0x4 in the same cycle as a new adc_valid[2] -> bit stays 1.
- Push read command (0x08 wdata=0x2), pop it, spi_rsp_valid with 0xDEADBEEF -> 0x20 reads 0xDEADBEEF, STATUS[16]=1. W1C 0x10000 -> clears.
- With the snapshot macro: capture ch0=0x111, snapshot, capture ch0=0x222 -> 0x40 reads 0x111. Without the macro -> 0x222.
